// File: rtl/fifo_pkg.sv
// Shared sizing helpers and constants for the single-port-RAM backed FIFO.
package fifo_pkg;

    localparam int OB_DEPTH = 2;

    typedef logic [1:0] ob_cnt_t;

    // Pointer width: bank address bits plus one wrap bit.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_out_buf.sv
// Two-entry output buffer giving the downstream side a registered valid/ready
// interface. The head word is always presented on m_data.
module fifo_out_buf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output ob_cnt_t               ob_cnt
);

    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] tail;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ob_cnt <= '0;
            head   <= '0;
            tail   <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (ob_cnt == 2'd0) head <= push_data;
                    else                tail <= push_data;
                    ob_cnt <= ob_cnt + 2'd1;
                end
                2'b01: begin
                    head   <= tail;
                    ob_cnt <= ob_cnt - 2'd1;
                end
                2'b11: begin
                    // A pop needs a word present, so ob_cnt is 1 or 2 here.
                    if (ob_cnt == 2'd1) begin
                        head <= push_data;
                    end else begin
                        head <= tail;
                        tail <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_valid = (ob_cnt != 2'd0);
    assign m_data  = head;

endmodule

// File: rtl/fifo_spram_ctrl.sv
// Valid/ready FIFO controller around an external single-port bank: pointers,
// collision tracking, read scheduling into the output buffer and status.
module fifo_spram_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  bank_wen,
    output logic [ADDR_WIDTH-1:0] bank_waddr,
    output logic [DATA_WIDTH-1:0] bank_wdata,
    output logic                  bank_ren,
    output logic [ADDR_WIDTH-1:0] bank_raddr,
    input  logic [DATA_WIDTH-1:0] bank_rdata,
    output logic [ADDR_WIDTH+1:0] count,
    output logic                  full,
    output logic                  empty
);

    localparam int PTR_W = ptr_w(FIFO_DEPTH);
    typedef logic [PTR_W-1:0] ptr_t;

    ptr_t       wr_ptr;
    ptr_t       rd_ptr;
    ptr_t       mem_cnt;
    logic       pend;
    logic       infl;
    logic       rst_done;
    logic       pop;
    ob_cnt_t    ob_cnt;
    logic [2:0] ob_load;
    logic [2:0] ob_room;

    assign mem_cnt    = wr_ptr - rd_ptr;
    assign full       = (mem_cnt == ptr_t'(FIFO_DEPTH));
    assign s_ready    = ~full & ~pend & rst_done;
    assign bank_wen   = s_valid & s_ready;
    assign bank_waddr = wr_ptr[ADDR_WIDTH-1:0];
    assign bank_wdata = s_data;

    // Only fetch when the buffer can absorb the word once it lands, counting
    // the word already in flight and a pop happening this cycle.
    assign pop        = m_valid & m_ready;
    assign ob_load    = {1'b0, ob_cnt} + {2'b00, infl};
    assign ob_room    = 3'(OB_DEPTH) + {2'b00, pop};
    assign bank_ren   = (mem_cnt != '0) & ~pend & (ob_load < ob_room);
    assign bank_raddr = rd_ptr[ADDR_WIDTH-1:0];

    // pend covers the cycle in which the bank commits a deferred write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            pend     <= 1'b0;
            infl     <= 1'b0;
            rst_done <= 1'b0;
        end else begin
            rst_done <= 1'b1;
            pend     <= bank_wen & bank_ren;
            infl     <= bank_ren;
            if (bank_wen) wr_ptr <= wr_ptr + ptr_t'(1);
            if (bank_ren) rd_ptr <= rd_ptr + ptr_t'(1);
        end
    end

    fifo_out_buf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_out_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (infl),
        .push_data(bank_rdata),
        .pop      (pop),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .ob_cnt   (ob_cnt)
    );

    assign count = {1'b0, mem_cnt}
                 + {{(ADDR_WIDTH+1){1'b0}}, infl}
                 + {{ADDR_WIDTH{1'b0}}, ob_cnt};
    assign empty = (count == '0);

endmodule
